// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;
  localparam int W_DEF     = 32;
  localparam int ITER_LAST = 31;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;
endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: right-shift shift-add multiply or left-shift
// restoring divide on a {hi_half, lo_half} accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  input  logic           is_div,
  output logic [2*W-1:0] acc_nxt,
  output logic           qbit
);
  logic [W:0]   add_sum;
  logic [W:0]   rem_sh;
  logic [W-1:0] rem_sub;

  always_comb begin
    add_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    rem_sh  = acc[2*W-1:W-1];
    // The difference always fits W bits when the subtract is taken.
    rem_sub = rem_sh[W-1:0] - opnd;
    qbit    = is_div && (rem_sh >= {1'b0, opnd});
    if (is_div)
      acc_nxt = {(qbit ? rem_sub : rem_sh[W-1:0]), acc[W-2:0], 1'b0};
    else
      acc_nxt = {add_sum, acc[W-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; also services MTHI/MTLO.
// Optional MULDIV_EARLY_EXIT_EN: multiply exits once remaining multiplier bits are zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int CW = $clog2(W);

  state_e         state;
  logic [CW-1:0]  count;
  logic [2*W-1:0] acc, acc_nxt;
  logic [W-1:0]   opnd;
  logic           is_div_r, neg_q, neg_r;
  logic           qbit, early;
  logic           div_in, sgn_in;
  logic [W-1:0]   abs_a, abs_b;
  logic [CW-1:0]  shamt;
  logic [2*W-1:0] prod, mres;
  logic [W-1:0]   res_hi, res_lo;

  function automatic logic [W-1:0] cneg_w(input logic [W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*W-1:0] cneg_2w(input logic [2*W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign div_in = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn_in = (op == OP_MULT) || (op == OP_DIV);
  assign abs_a  = cneg_w(rs_val, sgn_in && rs_val[W-1]);
  assign abs_b  = cneg_w(rt_val, sgn_in && rt_val[W-1]);

  muldiv_step #(.W(W)) u_step (
    .acc     (acc),
    .opnd    (opnd),
    .is_div  (is_div_r),
    .acc_nxt (acc_nxt),
    .qbit    (qbit)
  );

`ifdef MULDIV_EARLY_EXIT_EN
  // Multiplier bits still to be consumed sit below the product bits in the low half.
  assign early = !is_div_r &&
                 ((acc_nxt[W-1:0] & ({W{1'b1}} >> (count + 1'b1))) == {W{1'b0}});
`else
  assign early = 1'b0;
`endif

  // Fix-up: realign an early-exited product, then apply result signs.
  always_comb begin
    shamt  = CW'(ITER_LAST) - count;
    prod   = acc >> shamt;
    mres   = cneg_2w(prod, neg_q);
    res_hi = mres[2*W-1:W];
    res_lo = mres[W-1:0];
    if (is_div_r) begin
      res_hi = cneg_w(acc[2*W-1:W], neg_r);
      res_lo = (opnd == {W{1'b0}}) ? {W{1'b1}} : cneg_w(acc[W-1:0], neg_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div_r <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            count    <= '0;
            div_zero <= 1'b0;
            is_div_r <= div_in;
            neg_q    <= sgn_in && (rs_val[W-1] ^ rt_val[W-1]);
            neg_r    <= sgn_in && rs_val[W-1];
            acc      <= {{W{1'b0}}, (div_in ? abs_a : abs_b)};
            opnd     <= div_in ? abs_b : abs_a;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          acc <= acc_nxt | {{(2*W-1){1'b0}}, qbit};
          if (count == CW'(ITER_LAST) || early) state <= FIX;
          else                                  count <= count + 1'b1;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          if (is_div_r && opnd == {W{1'b0}}) div_zero <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          count <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
